am_match_detector: RTL and testbench

AM_MATCH_DETECTOR -- requirements
Module: am_match_detector

---
 rtl/pcs_am_pkg.sv | 45 ++++
 rtl/am_block_timer.sv | 50 +++++
 rtl/am_match_detector.sv | 100 ++++++++++
 tb/tb_am_match_detector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pcs_am_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pcs_am_pkg
// Description : Alignment-marker constants and lookup table shared by the
//               PCS lane-alignment blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pcs_am_pkg;

  localparam int         N_ALIGNERS    = 20;
  localparam int         NB_LANE_ID    = 5;
  localparam int         NB_AM_PATTERN = 48;
  localparam logic [1:0] SH_CTRL       = 2'b10;

  // Each entry packs {M0,M1,M2,M4,M5,M6}; the BIP3/BIP7 bytes are not part of the pattern.
  typedef logic [NB_AM_PATTERN-1:0] am_pattern_t;

  function automatic am_pattern_t am_pattern(input int unsigned lane);
    case (lane)
      0:       am_pattern = 48'hC16821_3E97DE;
      1:       am_pattern = 48'h9D718E_628E71;
      2:       am_pattern = 48'h594BE8_A6B417;
      3:       am_pattern = 48'h4D957B_B26A84;
      4:       am_pattern = 48'hF50709_0AF8F6;
      5:       am_pattern = 48'hDD14C2_22EB3D;
      6:       am_pattern = 48'h9A4A26_65B5D9;
      7:       am_pattern = 48'h7B4566_84BA99;
      8:       am_pattern = 48'hA02476_5FDB89;
      9:       am_pattern = 48'h68C9FB_973604;
      10:      am_pattern = 48'hFD6C99_029366;
      11:      am_pattern = 48'hB99155_466EAA;
      12:      am_pattern = 48'h5CB9B2_A3464D;
      13:      am_pattern = 48'h1AF8BD_E50742;
      14:      am_pattern = 48'h83C7CA_7C3835;
      15:      am_pattern = 48'h3536CD_CAC932;
      16:      am_pattern = 48'hC4314C_3BCEB3;
      17:      am_pattern = 48'hADD6B7_522948;
      18:      am_pattern = 48'h5F662A_A099D5;
      19:      am_pattern = 48'hC0F0E5_3F0F1A;
      default: am_pattern = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/am_block_timer.sv
`default_nettype none
// ============================================================================
// Module      : am_block_timer
// Description : Counts accepted blocks and flags the block expected to be an AM.
// Revision    : 1.0 - initial release
// ============================================================================
module am_block_timer #(
  parameter int N_BLOCKS = 16383,
  parameter int NB_CNT   = $clog2(N_BLOCKS + 2)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_accept,
  input  logic i_reset_count,
  output logic o_timer_done
);

  localparam logic [NB_CNT-1:0] WRAP = NB_CNT'(N_BLOCKS + 1);

  logic [NB_CNT-1:0] cnt_q, cnt_d, cnt_next;
  logic              done_q, done_d;

  // A restart request wins over the natural wrap; both land on 1.
  always_comb begin
    cnt_next = cnt_q + 1'b1;
    if (i_reset_count || (cnt_q == WRAP)) begin
      cnt_next = NB_CNT'(1);
    end
    cnt_d  = cnt_q;
    done_d = done_q;
    if (i_accept) begin
      cnt_d  = cnt_next;
      done_d = (cnt_next == WRAP);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_timer_done = done_q;

endmodule
`default_nettype wire

// File: rtl/am_match_detector.sv
`default_nettype none
// ============================================================================
// Module      : am_match_detector
// Description : Per-lane alignment-marker detection with block-position timer.
// Revision    : 1.0 - initial release
// ============================================================================
module am_match_detector #(
  parameter int N_ALIGNERS = pcs_am_pkg::N_ALIGNERS,
  parameter int N_BLOCKS   = 16383,
  parameter int NB_CNT     = $clog2(N_BLOCKS + 2)
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_enable,
  input  logic                              i_valid,
  input  logic [65:0]                       i_data,
  input  logic                              i_ignore_sh,
  input  logic                              i_enable_mask,
  input  logic [N_ALIGNERS-1:0]             i_match_mask,
  input  logic                              i_reset_count,
  output logic                              o_valid,
  output logic [65:0]                       o_data,
  output logic [N_ALIGNERS-1:0]             o_match_vector,
  output logic                              o_am_valid,
  output logic [pcs_am_pkg::NB_LANE_ID-1:0] o_lane_id,
  output logic                              o_timer_done
);

  import pcs_am_pkg::*;

  logic                  accept;
  logic                  sh_ok;
  logic [N_ALIGNERS-1:0] raw;
  logic [N_ALIGNERS-1:0] match_d, match_q;
  logic [NB_LANE_ID-1:0] lane_d, lane_q;
  logic                  am_valid_d, am_valid_q;
  logic [65:0]           data_d, data_q;
  logic                  valid_q;

  assign accept = i_enable & i_valid;
  assign sh_ok  = i_ignore_sh | (i_data[65:64] == SH_CTRL);

  generate
    for (genvar j = 0; j < N_ALIGNERS; j++) begin : g_cmp
      am_pattern_t pat;
      assign pat    = am_pattern(j);
      assign raw[j] = sh_ok && (i_data[63:40] == pat[47:24]) && (i_data[31:8] == pat[23:0]);
    end
  endgenerate

  always_comb begin
    match_d = i_enable_mask ? (raw & i_match_mask) : raw;
    am_valid_d = |match_d;
    // Scan downward so the lowest set index is the one left standing.
    lane_d = '0;
    for (int j = N_ALIGNERS - 1; j >= 0; j--) begin
      if (match_d[j]) begin
        lane_d = NB_LANE_ID'(j);
      end
    end
    data_d = i_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      match_q    <= '0;
      am_valid_q <= 1'b0;
      lane_q     <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        data_q     <= data_d;
        match_q    <= match_d;
        am_valid_q <= am_valid_d;
        lane_q     <= lane_d;
      end
    end
  end

  am_block_timer #(
    .N_BLOCKS (N_BLOCKS),
    .NB_CNT   (NB_CNT)
  ) u_timer (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_accept      (accept),
    .i_reset_count (i_reset_count),
    .o_timer_done  (o_timer_done)
  );

  assign o_valid        = valid_q;
  assign o_data         = data_q;
  assign o_match_vector = match_q;
  assign o_am_valid     = am_valid_q;
  assign o_lane_id      = lane_q;

endmodule
`default_nettype wire

// File: tb/tb_am_match_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_am_match_detector
// Description : Scoreboard bench for am_match_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_am_match_detector;

  localparam int NB = 16383;

  typedef struct {
    logic [65:0] data;
    logic [19:0] mv;
    logic        am;
    logic [4:0]  lane;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_valid, i_ignore_sh, i_enable_mask, i_reset_count;
  logic [65:0] i_data;
  logic [19:0] i_match_mask;
  logic        o_valid, o_am_valid, o_timer_done;
  logic [65:0] o_data;
  logic [19:0] o_match_vector;
  logic [4:0]  o_lane_id;

  exp_t sb[$];
  int   done_at[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   acc    = 0;
  int   mcnt   = 0;
  logic [65:0] last_data;

  always #5 clk = ~clk;

  am_match_detector #(.N_ALIGNERS(20), .N_BLOCKS(NB)) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_ignore_sh    (i_ignore_sh),
    .i_enable_mask  (i_enable_mask),
    .i_match_mask   (i_match_mask),
    .i_reset_count  (i_reset_count),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_match_vector (o_match_vector),
    .o_am_valid     (o_am_valid),
    .o_lane_id      (o_lane_id),
    .o_timer_done   (o_timer_done)
  );

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [65:0] d, input logic ign, input logic em,
                      input logic [19:0] m, input logic rc,
                      input logic [19:0] emv, input logic [4:0] elane);
    exp_t e;
    @(posedge clk); #1;
    i_enable = 1'b1; i_valid = 1'b1; i_data = d;
    i_ignore_sh = ign; i_enable_mask = em; i_match_mask = m; i_reset_count = rc;
    if (rc || mcnt == NB + 1) mcnt = 1;
    else                      mcnt = mcnt + 1;
    e.data = d; e.mv = emv; e.am = |emv; e.lane = elane; e.done = (mcnt == NB + 1);
    sb.push_back(e);
    last_data = d;
    acc++;
  endtask

  task automatic filler(input logic rc);
    send({2'b01, 32'hF00D0000, acc[31:0]}, 1'b0, 1'b0, 20'h0, rc, 20'h0, 5'd0);
  endtask

  // Non-accepted cycles; n must be at least 2.
  task automatic gap(input int n, input logic en, input logic vld);
    @(posedge clk); #1;
    i_enable = en; i_valid = vld; i_reset_count = 1'b0;
    i_data = {2'b10, 64'hC168215A3E97DEA5};
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    chk("gap_valid", {65'h0, o_valid}, 66'h0);
    chk("gap_hold_data", o_data, last_data);
  endtask

  initial begin : monitor
    exp_t e;
    int   pidx;
    pidx = 0;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got o_valid=1 with no block pending, required none");
        end else begin
          e = sb.pop_front();
          if ({o_data, o_match_vector, o_am_valid, o_lane_id, o_timer_done} !==
              {e.data, e.mv, e.am, e.lane, e.done}) begin
            n_fail++;
            $display("FAIL block_%0d: got data=%h mv=%h am=%b lane=%0d done=%b required data=%h mv=%h am=%b lane=%0d done=%b",
                     pidx, o_data, o_match_vector, o_am_valid, o_lane_id, o_timer_done,
                     e.data, e.mv, e.am, e.lane, e.done);
          end
          if (o_timer_done === 1'b1) done_at.push_back(pidx);
          pidx++;
        end
      end
    end
  end

  initial begin : watchdog
    #(10 * 200000);
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : stimulus
    int k_rc, r1, wait_cyc;
    int exp_done[3];
    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_data = '0;
    i_ignore_sh = 1'b0; i_enable_mask = 1'b0; i_match_mask = '0; i_reset_count = 1'b0;
    last_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o_valid, o_data, o_am_valid, o_timer_done},
        {1'b0, 66'h0, 1'b0, 1'b0});
    chk("reset_mv_lane", {41'h0, o_match_vector, o_lane_id}, 66'h0);
    i_reset = 1'b0;

    // Directed AM patterns
    send({2'b10, 64'hC168215A3E97DEA5}, 1'b0, 1'b0, 20'h00000, 1'b0, 20'h00001, 5'd0);
    send({2'b01, 64'h9D718E00628E7100}, 1'b0, 1'b0, 20'h00000, 1'b0, 20'h00000, 5'd0);
    send({2'b01, 64'h9D718E00628E7100}, 1'b1, 1'b0, 20'h00000, 1'b0, 20'h00002, 5'd1);
    send({2'b10, 64'h9D718E00628E7100}, 1'b0, 1'b1, 20'h00001, 1'b0, 20'h00000, 5'd0);
    send({2'b10, 64'h9D718E00628E7100}, 1'b0, 1'b1, 20'h00002, 1'b0, 20'h00002, 5'd1);
    send({2'b10, 64'hC0F0E5003F0F1A00}, 1'b0, 1'b0, 20'h00000, 1'b0, 20'h80000, 5'd19);
    send({2'b10, 64'h7B4566FF84BA9911}, 1'b0, 1'b0, 20'h00000, 1'b0, 20'h00080, 5'd7);
    send({2'b10, 64'hC16821003E96DE00}, 1'b0, 1'b0, 20'h00000, 1'b0, 20'h00000, 5'd0);
    send({2'b11, 64'hC168215A3E97DEA5}, 1'b0, 1'b0, 20'h00000, 1'b0, 20'h00000, 5'd0);
    send({2'b00, 64'hC168215A3E97DEA5}, 1'b0, 1'b0, 20'h00000, 1'b0, 20'h00000, 5'd0);
    send({2'b10, 64'h5CB9B2C3A3464D77}, 1'b0, 1'b1, 20'hFFFFF, 1'b0, 20'h01000, 5'd12);
    gap(3, 1'b0, 1'b1);

    // Timer restart, then two full periods with stalls inside the first
    k_rc = acc;
    filler(1'b1);
    for (int i = 1; i <= NB; i++) begin
      if (i == 8000) gap(5, 1'b1, 1'b0);
      filler(1'b0);
    end
    for (int i = 0; i < NB + 1; i++) filler(1'b0);
    for (int i = 0; i < 100; i++) filler(1'b0);

    // Reset mid-period with a block in flight
    @(posedge clk); #1;
    i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b1; i_reset_count = 1'b0;
    i_data = {2'b10, 64'hC168215A3E97DEA5};
    mcnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_outputs", {o_valid, o_data, o_am_valid, o_timer_done},
        {1'b0, 66'h0, 1'b0, 1'b0});
    chk("midreset_mv_lane", {41'h0, o_match_vector, o_lane_id}, 66'h0);
    i_reset = 1'b0; i_valid = 1'b0;

    r1 = acc;
    for (int i = 0; i < NB + 1; i++) filler(1'b0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_enable = 1'b0;

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    chk("scoreboard_drained", 66'(sb.size()), 66'h0);

    exp_done[0] = k_rc + NB;
    exp_done[1] = k_rc + NB + (NB + 1);
    exp_done[2] = r1 + NB;
    chk("done_count", 66'(done_at.size()), 66'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < done_at.size()) chk($sformatf("done_pos_%0d", i), 66'(done_at[i]), 66'(exp_done[i]));
      else                    chk($sformatf("done_pos_%0d", i), 66'h3FFFFFFFF, 66'(exp_done[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
